uart_rx_ld: RTL and testbench
=============================

UART_RX_LD -- requirements
Module: uart_rx_ld

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 rx  input  1  asynchronous serial line, idle high.
REQ-005 data_out  output  8  last correctly received byte; held between frames.
REQ-006 ld  output  1  one-cycle strobe, high for the single cycle in which data_out first shows a new byte; drives the ld input of a downstream n-bit load register directly.
REQ-007 frame_err  output  1  one-cycle strobe, high when the stop bit samples low.
REQ-008 parity_err  output  1  one-cycle strobe, high on a parity mismatch; constant 0 when parity is compiled out.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer before any use; "rxs" below is the synchronized value; synchronizer flops load 1 on reset.
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-011 IDLE: on rxs=0, clear the baud counter and go to START.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer divide), sample rxs; if 0 go to DATA, else return to IDLE (glitch reject) with no strobe.
REQ-013 DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first, into an internal shift register; data_out SHALL NOT change during DATA.
REQ-014 After the 8th data sample go to PARITY if parity is enabled, else to STOP.
REQ-015 PARITY: sample after CLKS_PER_BIT cycles; mismatch is recorded for the STOP decision.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; if rxs=1 and no parity mismatch, copy the shift register to data_out and pulse ld in the next cycle, then go to IDLE.
REQ-017 STOP with rxs=1 and a parity mismatch: pulse parity_err, leave data_out unchanged, no ld, go to IDLE.
REQ-018 STOP with rxs=0: pulse frame_err (plus parity_err if there is also a mismatch), leave data_out unchanged, no ld, go to BREAK.
REQ-019 BREAK: remain until rxs=1, then go to IDLE; a low line SHALL NOT start a new frame.
REQ-020 ld, frame_err and parity_err SHALL each be high for exactly one cycle per event and never high together with ld.
REQ-021 Back-to-back frames: a start bit arriving in the cycle after the STOP to IDLE transition SHALL be accepted with no lost frame.
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 on every state entry.

Reset
REQ-023 clr=1 at a clock edge: state is IDLE, counters 0, shift register 0x00, data_out 0x00, ld/frame_err/parity_err 0, synchronizer flops 1.
REQ-024 clr asserted mid-frame SHALL abort the frame without any strobe; after release, reception resumes only on a fresh falling edge.
REQ-025 clr has priority over every other event in the same cycle.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, frames are start + 8 data + 1 even-parity bit + stop, and the PARITY state is used.
REQ-027 When UART_RX_PARITY_EN is undefined, frames are 8N1, PARITY is unreachable, parity_err is tied 0, and the port list is unchanged.

Verification (CLKS_PER_BIT=16)
REQ-028 Without the macro, send 8N1 byte 0xA5 -> data_out=0xA5, ld high for exactly 1 cycle about 152 cycles after the start edge, no error strobes.
REQ-029 Send 0x3C then 0xC3 back-to-back with zero idle -> two ld pulses, data_out=0x3C then 0xC3.
REQ-030 Drive rx low for 4 cycles then high -> no strobes, state returns to IDLE, data_out unchanged.
REQ-031 Send 0x55 with the stop bit held low for 40 cycles -> frame_err pulse, no ld, data_out keeps its prior value, no new frame until rx returns high.
REQ-032 With the macro, send 0x07 with parity bit 0 (wrong; correct even parity is 1) -> parity_err pulse, no ld; resend with parity bit 1 -> ld, data_out=0x07.
REQ-033 Assert clr during data bit 4 of frame 0xFF -> all outputs 0 at the next edge, no strobe; a following frame 0x81 -> data_out=0x81.

Source files
------------

// File: rtl/uart_rx_ld.sv
// 8-bit UART receiver that presents each good byte on data_out with a one-cycle ld strobe.
// Build option: define UART_RX_PARITY_EN for start + 8 data + even parity + stop frames.
module uart_rx_ld #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       ld,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Handshake: ld is a single-cycle qualifier for data_out, no back-pressure;
    // the strobe cycle is the first cycle data_out holds the new byte.
    state_t          state, state_n;
    logic            rx_meta, rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      data_q;
    logic            ld_q, fe_q, pe_q;
    logic            ld_n, fe_n, pe_n;
    logic            bit_last, half_last;

    assign bit_last  = (cnt == FULL_M1);
    assign half_last = (cnt == HALF_M1);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic par_bad;
    always_ff @(posedge clk) begin
        if (clr) begin
            par_bad <= 1'b0;
        end else if (state == IDLE) begin
            par_bad <= 1'b0;
        end else if (state == PARITY && bit_last) begin
            par_bad <= rxs ^ (^shift);
        end
    end
`else
    localparam bit PAR_EN = 1'b0;
    logic par_bad;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ld_n    = 1'b0;
        fe_n    = 1'b0;
        pe_n    = 1'b0;
        case (state)
            IDLE:   if (!rxs) state_n = START;
            START:  if (half_last) state_n = rxs ? IDLE : DATA;
            DATA:   if (bit_last && bit_idx == 3'd7) state_n = PAR_EN ? PARITY : STOP;
            PARITY: if (bit_last) state_n = STOP;
            STOP: begin
                if (bit_last) begin
                    if (rxs) begin
                        state_n = IDLE;
                        ld_n    = !par_bad;
                        pe_n    = par_bad;
                    end else begin
                        // A low stop bit means a break or lost framing; wait for the line to recover.
                        state_n = BREAK;
                        fe_n    = 1'b1;
                        pe_n    = par_bad;
                    end
                end
            end
            BREAK:  if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            ld_q    <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state   <= state_n;
            ld_q    <= ld_n;
            fe_q    <= fe_n;
            pe_q    <= pe_n;
            if (state_n != state || state == IDLE || state == BREAK) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end
            if (state == DATA && bit_last) begin
                shift   <= {rxs, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (ld_n) begin
                data_q <= shift;
            end
        end
    end

    assign data_out   = data_q;
    assign ld         = ld_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;

endmodule

// File: tb/tb_uart_rx_ld.sv
// Directed bench for uart_rx_ld at 16 clocks per bit; honours UART_RX_PARITY_EN if defined.
module tb_uart_rx_ld;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    // rx driven low, then 2 sync + 8 half bit + 128 data + 16 stop edges, ld seen one cycle on
    localparam int LAT = 155;
`endif

    logic       clk;
    logic       clr;
    logic       rx;
    logic [7:0] data_out;
    logic       ld;
    logic       frame_err;
    logic       parity_err;

    uart_rx_ld #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .clr        (clr),
        .rx         (rx),
        .data_out   (data_out),
        .ld         (ld),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ld_cnt = 0, fe_cnt = 0, pe_cnt = 0;
    int last_ld_cyc = 0;
    int start_cyc = 0;
    logic prev_ld = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks; every task starts and ends on a falling edge
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] b);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_body(b);
        drive_bit(1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (ld) begin
            ld_cnt++;
            last_ld_cyc = cyc;
            check("ld_width", 32'(prev_ld), 0);
            check("ld_excl", 32'(frame_err | parity_err), 0);
            if (exp_q.size() == 0) check("ld_unexpected", 32'(ld), 0);
            else check("ld_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
        if (frame_err) begin
            fe_cnt++;
            check("fe_width", 32'(prev_fe), 0);
        end
        if (parity_err) begin
            pe_cnt++;
            check("pe_width", 32'(prev_pe), 0);
        end
        prev_ld = ld;
        prev_fe = frame_err;
        prev_pe = parity_err;
    end

    int ld0, fe0, pe0;

    initial begin
        clr = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 0);
        check("rst_ld", 32'(ld), 0);
        check("rst_fe", 32'(frame_err), 0);
        check("rst_pe", 32'(parity_err), 0);
        check("rst_state", 32'(dut.state), 0);
        clr = 1'b0;
        idle(5);

        // single byte and latency
        exp_q.push_back(8'hA5);
        ld0 = ld_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        send_frame(8'hA5);
        idle(10);
        check("a5_ld_count", 32'(ld_cnt - ld0), 1);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_latency", 32'(last_ld_cyc - start_cyc), 32'(LAT));
        check("a5_no_err", 32'(fe_cnt - fe0 + pe_cnt - pe0), 0);

        // back-to-back, zero idle between frames
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        ld0 = ld_cnt;
        send_frame(8'h3C);
        send_frame(8'hC3);
        idle(10);
        check("b2b_ld_count", 32'(ld_cnt - ld0), 2);
        check("b2b_data", 32'(data_out), 32'hC3);

        // short glitch on the line
        ld0 = ld_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_strobes", 32'(ld_cnt - ld0 + fe_cnt - fe0 + pe_cnt - pe0), 0);
        check("glitch_state", 32'(dut.state), 0);
        check("glitch_data", 32'(data_out), 32'hC3);

        // stop bit held low: frame error, then break until the line recovers
        ld0 = ld_cnt; fe0 = fe_cnt;
        send_body(8'h55);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("brk_state", 32'(dut.state), 5);
        check("brk_fe_count", 32'(fe_cnt - fe0), 1);
        idle(200);
        check("brk_no_ld", 32'(ld_cnt - ld0), 0);
        check("brk_fe_final", 32'(fe_cnt - fe0), 1);
        check("brk_data", 32'(data_out), 32'hC3);
        check("brk_idle", 32'(dut.state), 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity is 1; send 0 first
        ld0 = ld_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(10);
        check("par_pe_count", 32'(pe_cnt - pe0), 1);
        check("par_no_ld", 32'(ld_cnt - ld0), 0);
        check("par_no_fe", 32'(fe_cnt - fe0), 0);
        check("par_data_held", 32'(data_out), 32'hC3);
        exp_q.push_back(8'h07);
        send_frame(8'h07);
        idle(10);
        check("par_ok_ld", 32'(ld_cnt - ld0), 1);
        check("par_ok_data", 32'(data_out), 32'h07);
`endif

        // clr during data bit 4 of 0xFF
        ld0 = ld_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (CPB / 2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("clr_data", 32'(data_out), 0);
        check("clr_outs", 32'({ld, frame_err, parity_err}), 0);
        check("clr_state", 32'(dut.state), 0);
        clr = 1'b0;
        idle(200);
        check("clr_no_strobe", 32'(ld_cnt - ld0 + fe_cnt - fe0 + pe_cnt - pe0), 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        idle(10);
        check("post_clr_ld", 32'(ld_cnt - ld0), 1);
        check("post_clr_data", 32'(data_out), 32'h81);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
